// File: rtl/hls_drv_pkg.sv
// Shared definitions for the ap_ctrl_hs kernel driver: FSM states,
// default widths, job counter width and watchdog counter sizing.
package hls_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } drv_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int N_IN_DEF   = 10;
  localparam int JOBCNT_W   = 16;

  // Width of a counter that must reach cyc-1 (never narrower than one bit)
  function automatic int tmo_cnt_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/hls_drv_capture.sv
// One kernel result register: cleared when a job is launched so that an
// output whose strobe never fires reads back as zero, loaded on its strobe.
module hls_drv_capture
  import hls_drv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Clear has priority so a launch never inherits a stale strobe value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hls_kernel_driver.sv
// Initiator-side driver for an ap_ctrl_hs kernel. Takes operand sets from an
// upstream valid/ready stream, holds them on k_in for the whole job, drives
// ap_start until ap_done, captures the strobed outputs plus ap_return and
// offers them as one downstream result beat.
// Optional build macro HLS_DRV_TIMEOUT_EN adds a RUN-state watchdog that
// produces a zero-data beat with m_err=1 after TIMEOUT_CYC cycles.
module hls_kernel_driver
  import hls_drv_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int N_IN        = N_IN_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_IN*DATA_W-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_out1,
  output logic [DATA_W-1:0]      m_out2,
  output logic [DATA_W-1:0]      m_out3,
  output logic [DATA_W-1:0]      m_ret,
  output logic                   m_err,
  output logic                   k_start,
  input  logic                   k_done,
  input  logic                   k_idle,
  input  logic                   k_ready,
  output logic [N_IN*DATA_W-1:0] k_in,
  input  logic [DATA_W-1:0]      k_out1,
  input  logic [DATA_W-1:0]      k_out2,
  input  logic [DATA_W-1:0]      k_out3,
  input  logic                   k_out1_vld,
  input  logic                   k_out2_vld,
  input  logic                   k_out3_vld,
  input  logic [DATA_W-1:0]      k_return,
  output logic                   busy,
  output logic [JOBCNT_W-1:0]    job_cnt
);

  drv_state_t             r_state;
  drv_state_t             w_state_nxt;
  logic [N_IN*DATA_W-1:0] r_kin;
  logic [JOBCNT_W-1:0]    r_job_cnt;
  logic                   w_s_ready;
  logic                   w_s_fire;
  logic                   w_k_start;
  logic                   w_m_valid;
  logic                   w_in_run;
  logic                   w_expire;
  logic                   w_clr;
  logic                   w_err;
  logic                   w_unused;

  assign w_in_run = (r_state == ST_RUN);
  assign w_s_fire = s_valid & w_s_ready;
  // A watchdog expiry wipes the captures so the error beat carries zero data
  assign w_clr    = w_s_fire | w_expire;

`ifdef HLS_DRV_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_err;

  // k_done in the expiry cycle wins over the watchdog
  assign w_expire = w_in_run & ~k_done & (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count RUN cycles since the current job was launched
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_s_fire) begin
      r_tmo_cnt <= '0;
    end else if (w_in_run) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // Mark the pending result beat as produced by the watchdog
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_err <= 1'b0;
    end else if (w_s_fire) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign w_err    = r_err;
  // k_idle / k_ready are observation-only kernel signals
  assign w_unused = k_idle ^ k_ready;
`else
  assign w_expire = 1'b0;
  assign w_err    = 1'b0;
  assign w_unused = k_idle ^ k_ready ^ (TIMEOUT_CYC == 0);
`endif

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; OUT can relaunch directly into RUN
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_k_start   = 1'b0;
    w_m_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (s_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_k_start = 1'b1;
        if (k_done || w_expire) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_m_valid = 1'b1;
        w_s_ready = m_ready;
        if (m_ready) w_state_nxt = s_valid ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands change only on an accepted set, so k_in is stable per job
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_kin <= '0;
    end else if (w_s_fire) begin
      r_kin <= s_data;
    end
  end

  // Count delivered result beats, error beats included
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_job_cnt <= '0;
    end else if (w_m_valid && m_ready) begin
      r_job_cnt <= r_job_cnt + JOBCNT_W'(1);
    end
  end

  hls_drv_capture #(.DATA_W(DATA_W)) u_cap_out1 (
    .clk(ap_clk), .rst_n(ap_rst_n), .i_clr(w_clr),
    .i_load(w_in_run & k_out1_vld), .i_d(k_out1), .o_q(m_out1)
  );

  hls_drv_capture #(.DATA_W(DATA_W)) u_cap_out2 (
    .clk(ap_clk), .rst_n(ap_rst_n), .i_clr(w_clr),
    .i_load(w_in_run & k_out2_vld), .i_d(k_out2), .o_q(m_out2)
  );

  hls_drv_capture #(.DATA_W(DATA_W)) u_cap_out3 (
    .clk(ap_clk), .rst_n(ap_rst_n), .i_clr(w_clr),
    .i_load(w_in_run & k_out3_vld), .i_d(k_out3), .o_q(m_out3)
  );

  hls_drv_capture #(.DATA_W(DATA_W)) u_cap_ret (
    .clk(ap_clk), .rst_n(ap_rst_n), .i_clr(w_clr),
    .i_load(w_in_run & k_done), .i_d(k_return), .o_q(m_ret)
  );

  assign s_ready = w_s_ready;
  assign k_start = w_k_start;
  assign m_valid = w_m_valid;
  assign m_err   = w_err;
  assign k_in    = r_kin;
  assign busy    = (r_state != ST_IDLE);
  assign job_cnt = r_job_cnt;

endmodule

// File: tb/tb_hls_kernel_driver.sv
// Bench for hls_kernel_driver: reactive kernel model (out1=in1*in2,
// out2=in3+in4, out3=in5-in6, ret=sum), vector table, corner sequences and a
// randomized phase against a queue-based reference.
module tb_hls_kernel_driver;

  localparam int DW = 32;
  localparam int NI = 10;
`ifdef HLS_DRV_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic ap_clk, ap_rst_n;
  logic s_valid, s_ready, m_valid, m_ready, m_err, k_start, busy;
  logic [NI*DW-1:0] s_data, k_in;
  logic [DW-1:0] m_out1, m_out2, m_out3, m_ret;
  logic k_done, k_idle, k_ready, k_out1_vld, k_out2_vld, k_out3_vld;
  logic [DW-1:0] k_out1, k_out2, k_out3, k_return;
  logic [15:0] job_cnt;

  hls_kernel_driver #(.DATA_W(DW), .N_IN(NI), .TIMEOUT_CYC(TMO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_out1(m_out1), .m_out2(m_out2), .m_out3(m_out3), .m_ret(m_ret), .m_err(m_err),
    .k_start(k_start), .k_done(k_done), .k_idle(k_idle), .k_ready(k_ready),
    .k_in(k_in), .k_out1(k_out1), .k_out2(k_out2), .k_out3(k_out3),
    .k_out1_vld(k_out1_vld), .k_out2_vld(k_out2_vld), .k_out3_vld(k_out3_vld),
    .k_return(k_return), .busy(busy), .job_cnt(job_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  int exp_jobs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  typedef struct packed {
    logic [31:0] o1, o2, o3, r;
  } res_t;

  // Reference: what the driver must present for an operand set and strobe mask
  function automatic res_t ref_model(input logic [NI*DW-1:0] d, input logic [2:0] m);
    logic [31:0] p, q, s;
    res_t x;
    p = d[0*DW +: DW] * d[1*DW +: DW];
    q = d[2*DW +: DW] + d[3*DW +: DW];
    s = d[4*DW +: DW] - d[5*DW +: DW];
    x.o1 = m[0] ? p : 32'd0;
    x.o2 = m[1] ? q : 32'd0;
    x.o3 = m[2] ? s : 32'd0;
    x.r  = p + q + s;
    return x;
  endfunction

  function automatic logic [NI*DW-1:0] rnd_set();
    logic [NI*DW-1:0] d;
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = $urandom();
    return d;
  endfunction

  // ---------------- kernel model ----------------
  int klat = 5;
  logic [2:0] kmask = 3'b111;
  bit knever = 0, kspur = 0, krand = 0, kbusy = 0;
  int kcnt = 0;
  logic [NI*DW-1:0] kop;
  logic [2:0] mq[$];

  initial begin
    k_done = 0; k_idle = 1; k_ready = 0; k_return = 0;
    k_out1 = 0; k_out2 = 0; k_out3 = 0;
    k_out1_vld = 0; k_out2_vld = 0; k_out3_vld = 0;
    forever begin
      @(posedge ap_clk); #1;
      k_done = 0; k_ready = 0; k_out1_vld = 0; k_out2_vld = 0; k_out3_vld = 0;
      if (!ap_rst_n) begin
        kbusy = 0; k_idle = 1;
      end else if (kbusy && !k_start) begin
        kbusy = 0; k_idle = 1;
      end else if (!kbusy && k_start) begin
        kbusy = 1; kcnt = 1; k_idle = 0; kop = k_in;
        if (krand) begin
          klat = $urandom_range(2, 7);
          kmask = 3'($urandom_range(0, 7));
          mq.push_back(kmask);
        end
      end else if (kbusy) begin
        kcnt++;
      end else if (kspur) begin
        k_done = 1; k_out1_vld = 1; k_out2_vld = 1; k_out3_vld = 1;
        k_out1 = 32'hDEAD_BEEF; k_out2 = 32'hDEAD_BEEF;
        k_out3 = 32'hDEAD_BEEF; k_return = 32'hDEAD_BEEF;
      end
      if (kbusy && !knever && kcnt == klat) begin
        k_out1 = kop[0*DW +: DW] * kop[1*DW +: DW];
        k_out2 = kop[2*DW +: DW] + kop[3*DW +: DW];
        k_out3 = kop[4*DW +: DW] - kop[5*DW +: DW];
        k_return = k_out1 + k_out2 + k_out3;
        k_out1_vld = kmask[0]; k_out2_vld = kmask[1]; k_out3_vld = kmask[2];
        k_done = 1; k_ready = 1; kbusy = 0; k_idle = 1;
      end
    end
  end

  // ---------------- random-phase scoreboard ----------------
  bit mon_en = 0;
  logic [NI*DW-1:0] opq[$];

  always @(negedge ap_clk) begin
    if (mon_en) begin
      if (s_valid && s_ready) opq.push_back(s_data);
      if (m_valid && m_ready) begin
        if (opq.size() == 0 || mq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd_beat beat with no outstanding job");
        end else begin
          logic [NI*DW-1:0] rd;
          logic [2:0] rm;
          res_t rr;
          rd = opq.pop_front();
          rm = mq.pop_front();
          rr = ref_model(rd, rm);
          chk("rnd_out1", m_out1, rr.o1);
          chk("rnd_out2", m_out2, rr.o2);
          chk("rnd_out3", m_out3, rr.o3);
          chk("rnd_ret", m_ret, rr.r);
          chk("rnd_err", {31'd0, m_err}, 32'd0);
          exp_jobs++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic fire(input logic [NI*DW-1:0] d);
    int n;
    @(posedge ap_clk); #1;
    s_valid = 1; s_data = d;
    n = 0;
    @(negedge ap_clk);
    while (!s_ready && n < 100) begin @(negedge ap_clk); n++; end
    if (!s_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge ap_clk); #1;
    s_valid = 0;
  endtask

  // Returns the cycle index (s_fire = cycle 0) at which m_valid is seen
  task automatic wait_mv(inout int n);
    while (!m_valid && n < 100) begin @(negedge ap_clk); n++; end
    if (!m_valid) chk("m_valid_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] i1, i2, i3, i4, i5, i6;
    logic [2:0]  mask;
    int          lat;
    logic [31:0] e1, e2, e3, er;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    logic [NI*DW-1:0] d;
    int n;
    d = rnd_set();
    d[0*DW +: DW] = v.i1; d[1*DW +: DW] = v.i2; d[2*DW +: DW] = v.i3;
    d[3*DW +: DW] = v.i4; d[4*DW +: DW] = v.i5; d[5*DW +: DW] = v.i6;
    klat = v.lat; kmask = v.mask; m_ready = 1;
    fire(d);
    @(negedge ap_clk);
    chk($sformatf("v%0d_kstart_c1", idx), {31'd0, k_start}, 32'd1);
    chk($sformatf("v%0d_kin", idx), {31'd0, k_in == d}, 32'd1);
    n = 1;
    wait_mv(n);
    chk($sformatf("v%0d_latency", idx), n, v.lat + 1);
    chk($sformatf("v%0d_out1", idx), m_out1, v.e1);
    chk($sformatf("v%0d_out2", idx), m_out2, v.e2);
    chk($sformatf("v%0d_out3", idx), m_out3, v.e3);
    chk($sformatf("v%0d_ret", idx), m_ret, v.er);
    chk($sformatf("v%0d_err", idx), {31'd0, m_err}, 32'd0);
    exp_jobs++;
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk($sformatf("v%0d_mvalid_after", idx), {31'd0, m_valid}, 32'd0);
    chk($sformatf("v%0d_jobcnt", idx), {16'd0, job_cnt}, exp_jobs);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[5];

  initial begin
    logic [NI*DW-1:0] da, db, dc, dd;
    res_t ra, rb, rc;
    int n, bad_v, bad_d, bad_r, bad_k, beats, gap;

    tbl[0] = '{32'd3, 32'd4, 32'd10, 32'd5, 32'd9, 32'd2, 3'b111, 5,
               32'd12, 32'd15, 32'd7, 32'd34};
    tbl[1] = '{32'd3, 32'd4, 32'd10, 32'd5, 32'd9, 32'd2, 3'b101, 5,
               32'd12, 32'd0, 32'd7, 32'd34};
    tbl[2] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 3'b111, 3,
               32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{32'd100, 32'd200, 32'd7, 32'd8, 32'd1, 32'd5, 3'b000, 2,
               32'd0, 32'd0, 32'd0, 32'd20011};
    tbl[4] = '{32'h0001_0000, 32'h0001_0000, 32'd1, 32'd2, 32'd3, 32'd4, 3'b111, 8,
               32'd0, 32'd3, 32'hFFFF_FFFF, 32'd2};

    s_valid = 0; s_data = '0; m_ready = 0;
    ap_rst_n = 0;
    repeat (3) @(negedge ap_clk);
    chk("rst_kstart", {31'd0, k_start}, 32'd0);
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_jobcnt", {16'd0, job_cnt}, 32'd0);
    chk("rst_kin_zero", {31'd0, k_in == '0}, 32'd1);
    chk("rst_mret", m_ret, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1;

    // Vector table
    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Back-to-back: second set waits on s_valid while the first runs
    da = rnd_set(); db = rnd_set();
    ra = ref_model(da, 3'b111); rb = ref_model(db, 3'b111);
    klat = 4; kmask = 3'b111; m_ready = 1;
    @(posedge ap_clk); #1;
    s_valid = 1; s_data = da;
    @(negedge ap_clk);
    chk("b2b_accept_a", {31'd0, s_ready}, 32'd1);
    @(posedge ap_clk); #1;
    s_data = db;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("b2b_sready_run", {31'd0, s_ready}, 32'd0);
    chk("b2b_kin_held_a", {31'd0, k_in == da}, 32'd1);
    n = 2;
    wait_mv(n);
    chk("b2b_a_ret", m_ret, ra.r);
    chk("b2b_a_out3", m_out3, ra.o3);
    chk("b2b_sready_out", {31'd0, s_ready}, 32'd1);
    @(posedge ap_clk); #1;
    s_valid = 0;
    @(negedge ap_clk);
    chk("b2b_kstart_next", {31'd0, k_start}, 32'd1);
    chk("b2b_no_idle", {31'd0, busy}, 32'd1);
    chk("b2b_mvalid_drop", {31'd0, m_valid}, 32'd0);
    chk("b2b_kin_b", {31'd0, k_in == db}, 32'd1);
    n = 1;
    wait_mv(n);
    chk("b2b_b_latency", n, 5);
    chk("b2b_b_out1", m_out1, rb.o1);
    chk("b2b_b_ret", m_ret, rb.r);
    exp_jobs += 2;
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("b2b_jobcnt", {16'd0, job_cnt}, exp_jobs);

    // Backpressure: hold the beat for 10 cycles with another set offered
    dc = rnd_set(); dd = rnd_set();
    rc = ref_model(dc, 3'b111);
    klat = 3; kmask = 3'b111; m_ready = 0;
    fire(dc);
    s_valid = 1; s_data = dd;
    n = 1;
    wait_mv(n);
    bad_v = 0; bad_d = 0; bad_r = 0; bad_k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (m_valid !== 1'b1) bad_v++;
      if (m_out1 !== rc.o1 || m_out2 !== rc.o2 || m_out3 !== rc.o3 || m_ret !== rc.r) bad_d++;
      if (s_ready !== 1'b0) bad_r++;
      if (k_start !== 1'b0) bad_k++;
    end
    chk("bp_mvalid_held", bad_v, 0);
    chk("bp_data_stable", bad_d, 0);
    chk("bp_sready_low", bad_r, 0);
    chk("bp_kstart_low", bad_k, 0);
    @(posedge ap_clk); #1;
    s_valid = 0; m_ready = 1;
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      if (m_valid && m_ready) beats++;
    end
    chk("bp_one_beat", beats, 1);
    exp_jobs++;
    chk("bp_jobcnt", {16'd0, job_cnt}, exp_jobs);

    // Spurious done/strobes while idle
    @(posedge ap_clk); #1;
    kspur = 1;
    bad_v = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) bad_v++;
    end
    @(posedge ap_clk); #1;
    kspur = 0;
    @(negedge ap_clk);
    chk("spur_ignored", bad_v, 0);
    chk("spur_out1_kept", m_out1, rc.o1);
    chk("spur_ret_kept", m_ret, rc.r);
    chk("spur_jobcnt", {16'd0, job_cnt}, exp_jobs);

    // Reset in the middle of RUN (cycle 3)
    klat = 5; kmask = 3'b111; m_ready = 1;
    fire(rnd_set());
    @(posedge ap_clk);
    @(posedge ap_clk); #2;
    chk("mrst_busy_before", {31'd0, busy}, 32'd1);
    ap_rst_n = 0;
    #1;
    chk("mrst_kstart", {31'd0, k_start}, 32'd0);
    chk("mrst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("mrst_jobcnt", {16'd0, job_cnt}, 32'd0);
    exp_jobs = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1;
    run_vec(tbl[0], 10);

`ifdef HLS_DRV_TIMEOUT_EN
    // Watchdog: kernel never completes
    knever = 1; m_ready = 1;
    fire(rnd_set());
    n = 0;
    wait_mv(n);
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_err", {31'd0, m_err}, 32'd1);
    chk("tmo_out1", m_out1, 32'd0);
    chk("tmo_out2", m_out2, 32'd0);
    chk("tmo_out3", m_out3, 32'd0);
    chk("tmo_ret", m_ret, 32'd0);
    exp_jobs++;
    knever = 0;
    @(posedge ap_clk); #1;
    // done on the expiry cycle takes precedence
    run_vec(tbl[4], 20);
`endif

    // Randomized phase
    krand = 1; mon_en = 1;
    fork
      begin
        for (int j = 0; j < 30; j++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) @(posedge ap_clk);
          @(posedge ap_clk); #1;
          s_valid = 1; s_data = rnd_set();
          n = 0;
          @(negedge ap_clk);
          while (!s_ready && n < 200) begin @(negedge ap_clk); n++; end
          if (!s_ready) chk("rnd_accept_timeout", 32'd0, 32'd1);
          @(posedge ap_clk); #1;
          s_valid = 0;
        end
        n = 0;
        while (opq.size() != 0 && n < 500) begin @(negedge ap_clk); n++; end
        chk("rnd_drain", opq.size(), 0);
        mon_en = 0;
      end
      begin
        while (mon_en) begin
          @(posedge ap_clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    krand = 0; m_ready = 1;
    @(negedge ap_clk);
    chk("rnd_mask_q_empty", mq.size(), 0);
    chk("rnd_jobcnt", {16'd0, job_cnt}, exp_jobs);
    chk("rnd_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on simulation time
  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
